// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that lets two requesters share one
// combinational ALU. Each transaction is accept (IDLE) -> operand launch
// (EXEC) -> response hold (RESP). Operands and results are registered.
// Optional feature macro: ALU_ARB_STATS_EN adds per-requester saturating
// 16-bit grant counters (grant_cnt0 / grant_cnt1).
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CTRLW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [CTRLW-1:0] req0_op,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [CTRLW-1:0] req1_op,
  output logic             req1_ready,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [CTRLW-1:0] alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;
  logic             owner;
  logic             grant;
  logic             accept;
  logic             rsp_ack;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CTRLW-1:0] op_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;

  // Arbitration: contention goes to the requester that did not win last time.
  always_comb begin
    grant   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    accept  = (state == IDLE) && (req0_valid || req1_valid);
    rsp_ack = owner ? rsp1_ready : rsp0_ready;
  end

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: the default assignment before the case keeps this block free of
  // latches; every path leaves state_nxt defined.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs; readys are also gated by rst_n so they drop while reset is held.
  always_comb begin
    req0_ready = rst_n && (state == IDLE) && !grant && req0_valid;
    req1_ready = rst_n && (state == IDLE) &&  grant && req1_valid;
    rsp0_valid = (state == RESP) && !owner;
    rsp1_valid = (state == RESP) &&  owner;
  end

  // Operand capture on acceptance and result capture during EXEC.
  // NOTE: these are a handful of flops, not a memory array, so all of them
  // take the async reset and come up at known values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      result_q   <= '0;
      zero_q     <= 1'b0;
    end else begin
      if (accept) begin
        a_q        <= grant ? req1_a  : req0_a;
        b_q        <= grant ? req1_b  : req0_b;
        op_q       <= grant ? req1_op : req0_op;
        owner      <= grant;
        last_grant <= grant;
      end
      if (state == EXEC) begin
        result_q <= alu_result;
        zero_q   <= alu_zero;
      end
    end
  end

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_ctrl    = op_q;
  assign rsp0_result = result_q;
  assign rsp1_result = result_q;
  assign rsp0_zero   = zero_q;
  assign rsp1_zero   = zero_q;

`ifdef ALU_ARB_STATS_EN
  // Per-requester acceptance counters, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (accept) begin
      if (!grant && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
      if ( grant && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by a
// randomized run, all predicted by a transaction-level model (round-robin
// winner choice plus arithmetic ALU reference).
module tb_alu_arbiter;
  localparam int WIDTH = 32;
  localparam int CTRLW = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [CTRLW-1:0] req0_op, req1_op;
  logic             req0_ready, req1_ready;
  logic             rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero;
  logic [WIDTH-1:0] rsp0_result, rsp1_result;
  logic             rsp0_ready, rsp1_ready;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [CTRLW-1:0] alu_ctrl;
  logic             alu_zero;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]      grant_cnt0, grant_cnt1;
`endif

  int checks = 0;
  int errors = 0;
  int last_g = 1;
  int cnt0   = 0;
  int cnt1   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH), .CTRLW(CTRLW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .rsp1_ready(rsp1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  // Arithmetic meaning of the ALU control codes; unknown codes return 0.
  function automatic logic [WIDTH-1:0] alu_ref(input logic [CTRLW-1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return (a < b) ? WIDTH'(1) : WIDTH'(0);
      4'b1100: return ~(a | b);
      default: return '0;
    endcase
  endfunction

  // The shared ALU seen by the block.
  assign alu_result = alu_ref(alu_ctrl, alu_a, alu_b);
  assign alu_zero   = (alu_result == '0);

  // Round-robin rule: contention goes to whoever did not win last.
  function automatic int pick(input bit v0, input bit v1);
    if (v0 && v1) return 1 - last_g;
    return v1 ? 1 : 0;
  endfunction

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    @(posedge clk); #1;
    rst_n  = 1'b1;
    last_g = 1; cnt0 = 0; cnt1 = 0;
  endtask

  // One full transaction: wait for acceptance, check EXEC, RESP (held for
  // 'hold' cycles with the non-owner's rsp_ready asserted), then release.
  task automatic serve(input string tag, input int exp_owner, input bit drop,
                       input bit poke, input int hold);
    int n;
    logic [WIDTH-1:0] ea, eb, er;
    logic [CTRLW-1:0] eop;
    n = 0;
    #1;
    while (!(req0_ready || req1_ready) && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    check_b({tag, "_acc_wait"}, n < 20, 1'b1);
    check_b({tag, "_ready0"}, req0_ready, exp_owner == 0);
    check_b({tag, "_ready1"}, req1_ready, exp_owner == 1);
    ea  = (exp_owner == 1) ? req1_a  : req0_a;
    eb  = (exp_owner == 1) ? req1_b  : req0_b;
    eop = (exp_owner == 1) ? req1_op : req0_op;
    er  = alu_ref(eop, ea, eb);
    @(posedge clk); #1;
    last_g = exp_owner;
    if (exp_owner == 1) cnt1++; else cnt0++;
    if (drop) begin
      if (exp_owner == 1) req1_valid = 1'b0; else req0_valid = 1'b0;
    end
    if (poke) begin
      if (exp_owner == 1) req0_valid = 1'b1; else req1_valid = 1'b1;
    end
    #1;
    check_b({tag, "_exec_rdy"}, req0_ready | req1_ready, 1'b0);
    check_b({tag, "_exec_rsp"}, rsp0_valid | rsp1_valid, 1'b0);
    check({tag, "_alu_a"}, alu_a, ea);
    check({tag, "_alu_b"}, alu_b, eb);
    check({tag, "_alu_ctrl"}, WIDTH'(alu_ctrl), WIDTH'(eop));
    @(posedge clk); #2;
    for (int i = 0; i <= hold; i++) begin
      check_b({tag, "_rsp0_valid"}, rsp0_valid, exp_owner == 0);
      check_b({tag, "_rsp1_valid"}, rsp1_valid, exp_owner == 1);
      check({tag, "_result"}, (exp_owner == 1) ? rsp1_result : rsp0_result, er);
      check_b({tag, "_zero"}, (exp_owner == 1) ? rsp1_zero : rsp0_zero, er == '0);
      check_b({tag, "_resp_rdy"}, req0_ready | req1_ready, 1'b0);
      if (i < hold) begin
        if (exp_owner == 1) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        @(posedge clk); #2;
      end
    end
    rsp0_ready = (exp_owner == 0);
    rsp1_ready = (exp_owner == 1);
    @(posedge clk); #1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    check_b({tag, "_idle_rsp"}, rsp0_valid | rsp1_valid, 1'b0);
  endtask

  logic [CTRLW-1:0] ops [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
                                4'b0111, 4'b1100, 4'b1010};

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bit v0, v1;
    int exp;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #3;
    req0_valid = 1'b1;
    #1;
    check_b("rst_ready0", req0_ready, 1'b0);
    check_b("rst_ready1", req1_ready, 1'b0);
    check_b("rst_rsp0", rsp0_valid, 1'b0);
    check_b("rst_rsp1", rsp1_valid, 1'b0);
    check("rst_alu_a", alu_a, '0);
    check("rst_result", rsp0_result, '0);
    req0_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single requester: 5 + 3.
    req0_a = 32'd5; req0_b = 32'd3; req0_op = 4'b0010; req0_valid = 1'b1;
    serve("add53", 0, 1'b1, 1'b0, 0);
    check("add53_const", rsp0_result, 32'd8);

    // Contention from reset: requester 0 first (7-7=0), then requester 1 (1|2).
    do_reset();
    req0_a = 32'd7; req0_b = 32'd7; req0_op = 4'b0110; req0_valid = 1'b1;
    req1_a = 32'd1; req1_b = 32'd2; req1_op = 4'b0001; req1_valid = 1'b1;
    serve("both_r0", 0, 1'b1, 1'b0, 0);
    check_b("both_r0_zero_const", rsp0_zero, 1'b1);
    serve("both_r1", 1, 1'b1, 1'b0, 0);
    check("both_r1_const", rsp1_result, 32'd3);

    // Both held valid: grants alternate 0,1,0,1,0,1.
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      req0_a = $urandom; req0_b = $urandom; req0_op = ops[$urandom_range(0, 6)];
      req1_a = $urandom; req1_b = $urandom; req1_op = ops[$urandom_range(0, 6)];
      serve($sformatf("rr%0d", k), k % 2, 1'b0, 1'b0, 0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Stalled response on requester 1, requester 0 waiting meanwhile.
    req1_a = 32'd40; req1_b = 32'd2; req1_op = 4'b0110; req1_valid = 1'b1;
    req0_a = 32'd6;  req0_b = 32'd3; req0_op = 4'b0000;
    serve("stall", 1, 1'b1, 1'b1, 5);
    serve("stall_next", 0, 1'b1, 1'b0, 0);

    // Undefined op code passes the ALU's zero result back.
    req1_a = 32'hDEAD; req1_b = 32'hBEEF; req1_op = 4'b1111; req1_valid = 1'b1;
    serve("undef", 1, 1'b1, 1'b0, 0);

    // Reset during EXEC drops the transaction.
    req0_a = 32'd9; req0_b = 32'd4; req0_op = 4'b0110; req0_valid = 1'b1;
    #1;
    check_b("rexec_ready", req0_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_b("rexec_ready0", req0_ready, 1'b0);
    check_b("rexec_ready1", req1_ready, 1'b0);
    check_b("rexec_rsp0", rsp0_valid, 1'b0);
    check_b("rexec_rsp1", rsp1_valid, 1'b0);
    check("rexec_alu_a", alu_a, '0);
    req0_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_g = 1; cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      check_b("rexec_norsp", rsp0_valid | rsp1_valid, 1'b0);
    end
    req0_a = 32'd11; req0_b = 32'd4; req0_op = 4'b0010; req0_valid = 1'b1;
    serve("rexec_after", 0, 1'b1, 1'b0, 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 30; k++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      req0_a = $urandom; req0_b = $urandom_range(0, 3); req0_op = ops[$urandom_range(0, 6)];
      req1_a = $urandom; req1_b = $urandom_range(0, 3); req1_op = ops[$urandom_range(0, 6)];
      req0_valid = v0; req1_valid = v1;
      exp = pick(v0, v1);
      serve($sformatf("rnd%0d", k), exp, 1'b1, 1'b0, $urandom_range(0, 2));
      req0_valid = 1'b0; req1_valid = 1'b0;
    end

`ifdef ALU_ARB_STATS_EN
    check("rnd_cnt0", WIDTH'(grant_cnt0), WIDTH'(cnt0));
    check("rnd_cnt1", WIDTH'(grant_cnt1), WIDTH'(cnt1));
    do_reset();
    check("stat_rst0", WIDTH'(grant_cnt0), '0);
    for (int k = 0; k < 3; k++) begin
      req0_a = $urandom; req0_b = $urandom; req0_op = 4'b0010; req0_valid = 1'b1;
      serve($sformatf("stat0_%0d", k), 0, 1'b1, 1'b0, 0);
    end
    for (int k = 0; k < 2; k++) begin
      req1_a = $urandom; req1_b = $urandom; req1_op = 4'b0001; req1_valid = 1'b1;
      serve($sformatf("stat1_%0d", k), 1, 1'b1, 1'b0, 0);
    end
    check("stat_cnt0", WIDTH'(grant_cnt0), WIDTH'(3));
    check("stat_cnt1", WIDTH'(grant_cnt1), WIDTH'(2));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand and result width.
REQ-002 Parameter CTRLW, default 4, SHALL set the ALU control code width.
REQ-003 Port clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Ports reqN_valid (input, 1), reqN_a and reqN_b (input, WIDTH) and reqN_op (input, CTRLW), for N=0,1, SHALL carry the operation request from requester N.
REQ-006 Port reqN_ready  output  1  SHALL indicate that requester N's request is accepted this cycle.
REQ-007 Ports rspN_valid (output, 1), rspN_result (output, WIDTH), rspN_zero (output, 1) and rspN_ready (input, 1) SHALL form requester N's response handshake.
REQ-008 Ports alu_a and alu_b (output, WIDTH) and alu_ctrl (output, CTRLW) SHALL drive the shared ALU.
REQ-009 Ports alu_result (input, WIDTH) and alu_zero (input, 1) SHALL carry the combinational ALU outputs back to the block.

Function
REQ-010 FSM states SHALL be IDLE, EXEC and RESP; the reset state SHALL be IDLE.
REQ-011 In IDLE, reqN_ready SHALL be asserted combinationally only for the granted requester, and only when that requester's reqN_valid=1; both readys SHALL be 0 in EXEC and RESP.
REQ-012 Grant, single valid: the valid requester SHALL win.
REQ-013 Grant, both valid: the requester other than last_grant SHALL win (round-robin).
REQ-014 last_grant SHALL reset to 1, so requester 0 wins the first contention.
REQ-015 On acceptance (valid&&ready), a/b/op SHALL be latched into operand registers, the owner ID SHALL be latched, last_grant SHALL be updated, and the FSM SHALL move to EXEC.
REQ-016 alu_a, alu_b and alu_ctrl SHALL always be driven from the operand registers, never directly from the request ports.
REQ-017 In EXEC, alu_result and alu_zero SHALL be captured into response registers and the FSM SHALL move to RESP.
REQ-018 In RESP, rspN_valid SHALL be 1 only for the owner; rspN_result and rspN_zero SHALL be held stable until rspN_ready=1.
REQ-019 On owner rspN_ready=1 in RESP, the FSM SHALL return to IDLE.
REQ-020 The next acceptance SHALL occur no earlier than the cycle after that return to IDLE.
REQ-021 Latency SHALL be acceptance in cycle T and rsp valid in T+2; minimum issue interval is 3 cycles.
REQ-022 An op code is SHALL be forwarded unchecked; for an undefined code the ALU's returned value (0, zero=1) SHALL be passed back unaltered.
REQ-023 The non-owner's rspN_ready SHALL be ignored.
REQ-024 A reqN_valid deassertion in RESP SHALL NOT affect the transaction in flight.

Reset
REQ-025 rst_n low SHALL force state=IDLE, last_grant=1, operand, response and owner registers to 0, and all reqN_ready and rspN_valid outputs to 0, asynchronously.
REQ-026 Reset asserted during EXEC or RESP SHALL drop the transaction with no response issued; the first request after rst_n rises SHALL be accepted in IDLE normally.

Configuration
REQ-027 With macro ALU_ARB_STATS_EN defined, the block SHALL add outputs grant_cnt0 and grant_cnt1 (16 bits each) counting acceptances per requester, saturating at 16'hFFFF and reset to 0.
REQ-028 Without ALU_ARB_STATS_EN, those ports and counters SHALL be absent, and the remaining behaviour SHALL be identical.

Verification
REQ-029 Bench SHALL cover: req0 only, a=5, b=3, op=0010 -> req0_ready in T, rsp0_valid in T+2 with result=8, zero=0.
REQ-030 Bench SHALL cover: both valid from reset, req0 a=7,b=7,op=0110 and req1 a=1,b=2,op=0001 -> req0 served first (result 0, zero=1), then req1 (result 3).
REQ-031 Bench SHALL cover: both held valid continuously for 6 transactions -> grants alternate 0,1,0,1,0,1.
REQ-032 Bench SHALL cover: rsp1_ready held 0 for 5 cycles in RESP -> rsp1_valid and result stable throughout, no new acceptance, IDLE after rsp1_ready=1.
REQ-033 Bench SHALL cover: rst_n pulsed low during EXEC -> all valids/readys 0 immediately, no response, next req0 accepted after release.
REQ-034 Bench SHALL cover, with ALU_ARB_STATS_EN: 3 req0 and 2 req1 transactions -> grant_cnt0=3, grant_cnt1=2.
